card_shoe: RTL
==============

# card_shoe

Shuffled 52-card deck feeding the blackjack hand controllers. It sits upstream of the player and dealer hand logic and replaces the ad-hoc deck source. It holds the deck in a register array and shuffles it in hardware (Fisher-Yates, LFSR-driven). It serves one card per accepted draw request, and reshuffles on command, on a low-card threshold at round start, or when the deck empties.

## Interface
- LFSR_SEED, 16'hACE1, initial LFSR state; 0 is illegal and is replaced by 16'h0001.
- RESHUFFLE_THRESHOLD, 15, minimum cards remaining at i_newRound that avoids a reshuffle (range 1..52).

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_drawReq  in  1  draw request; sampled only while o_ready=1.
- i_shuffle  in  1  single-cycle pulse: force full reshuffle.
- i_newRound  in  1  single-cycle pulse: reshuffle if o_cardsRemaining < RESHUFFLE_THRESHOLD.
- o_card  out  6  {suit[1:0], rank[3:0]}; rank 1=Ace..13=King; suit 0..3.
- o_cardValid  out  1  one-cycle pulse; o_card valid only while high.
- o_ready  out  1  deck shuffled and non-empty; draws accepted.
- o_shuffling  out  1  high in INIT and SHUFFLE.
- o_cardsRemaining  out  6  undealt cards, 0..52.

## Operation
- Free-running 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every cycle in every state, so player key timing adds entropy.
  - Never reaches zero.
- States: INIT -> SHUFFLE -> IDLE.
- INIT: 52 cycles, k=0..51.
  - Writes deck[k] = {k/13, (k%13)+1}.
  - Sets top=0 and i=51.
- SHUFFLE: Fisher-Yates from i=51 down to i=1.
  - Each cycle takes r = LFSR[5:0].
  - If r <= i: swap deck[i] and deck[r] in that cycle, then decrement i.
  - Else: reject and retry next cycle.
  - After the i=1 swap: o_cardsRemaining=52, go to IDLE.
- IDLE, i_drawReq=1: o_card <= deck[top], o_cardValid <= 1, top <= top+1, o_cardsRemaining <= o_cardsRemaining-1.
- Reshuffle triggers in IDLE:
  - i_shuffle=1, or i_newRound=1 with post-draw remaining < RESHUFFLE_THRESHOLD, or the draw just dealt the last card.
  - Action: go to INIT, o_ready <= 0, o_cardsRemaining <= 0.
- Simultaneous draw and reshuffle trigger in IDLE: the draw is served (card delivered) and INIT is entered on the same edge.
- i_drawReq while o_ready=0: ignored; not queued; no o_cardValid.
- i_shuffle or i_newRound during INIT/SHUFFLE: ignored.
- Each card appears exactly once between consecutive shuffles.

## Timing
- All outputs are registered. Reset values:
  - o_card=0, o_cardValid=0, o_ready=0, o_shuffling=1, o_cardsRemaining=0.
  - State=INIT, k=0, LFSR=LFSR_SEED.
- Reset asserted mid-operation: outputs take reset values immediately (asynchronous). The shuffle restarts from INIT after release.
- Draw latency: request sampled at edge N, with o_ready=1 → o_cardValid=1 and o_card valid after edge N+1.
  - Back-to-back draws are accepted every cycle; throughput is 1 card/cycle.
- o_ready falls on the edge that deals the 52nd card or enters INIT.
- o_ready rises on the edge that completes the i=1 swap; o_shuffling falls on that same edge.
- Shuffle duration = 52 INIT cycles + 51 accepted steps + rejected cycles.
  - Minimum 103 cycles.
  - Expected under ~350 cycles.
- Deterministic: same seed and same cycle-exact stimulus give an identical card sequence.

## Test plan
- Reset release → o_shuffling=1 and o_ready=0 for ≥103 cycles; then o_ready=1, o_shuffling=0, o_cardsRemaining=52.
- 52 back-to-back draws → 52 o_cardValid pulses, each one cycle after its request. All 52 {suit,rank} values appear once. Remaining counts 52→0. o_ready drops after the last card and a reshuffle follows automatically.
- i_drawReq held during SHUFFLE → no o_cardValid; o_cardsRemaining stays 0 until shuffle completes.
- Deal to 20 remaining, pulse i_newRound → no reshuffle, remaining 20. Deal to 14, pulse i_newRound → INIT entered, later remaining 52.
- i_drawReq and i_shuffle in the same IDLE cycle with 40 remaining → one card delivered, o_ready=0 next cycle, remaining 52 after shuffle.
- Reset pulsed at shuffle step i=30 → outputs return to reset values at once. The first 10 cards after ready match a fresh run with identical stimulus.

Source files
------------

// File: rtl/card_shoe_if.sv
// Handshake bundle between the card shoe and the blackjack hand controllers.
// The hand logic drives the requests; the shoe drives the card and status.
interface card_shoe_if;
  logic       i_drawReq;
  logic       i_shuffle;
  logic       i_newRound;
  logic [5:0] o_card;
  logic       o_cardValid;
  logic       o_ready;
  logic       o_shuffling;
  logic [5:0] o_cardsRemaining;

  modport master (
    output i_drawReq, i_shuffle, i_newRound,
    input  o_card, o_cardValid, o_ready, o_shuffling, o_cardsRemaining
  );

  modport slave (
    input  i_drawReq, i_shuffle, i_newRound,
    output o_card, o_cardValid, o_ready, o_shuffling, o_cardsRemaining
  );
endinterface

// File: rtl/card_shoe.sv
// 52-card shoe: fills the deck in order, Fisher-Yates shuffles it from a free-running LFSR,
// then deals one card per accepted draw and reshuffles on command, low deck or empty deck.
module card_shoe #(
  parameter logic [15:0] LFSR_SEED           = 16'hACE1,
  parameter int          RESHUFFLE_THRESHOLD = 15
) (
  input  logic       i_clk,
  input  logic       i_reset,
  card_shoe_if.slave bus
);

  localparam logic [15:0] SEED   = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [5:0]  THRESH = 6'(RESHUFFLE_THRESHOLD);

  typedef enum logic [1:0] {INIT, SHUFFLE, IDLE} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [15:0] r_lfsr;
  logic [5:0]  r_deck [0:51];
  logic [5:0]  r_k;
  logic [5:0]  r_i;
  logic [5:0]  r_top;
  logic [5:0]  r_remaining;
  logic [5:0]  r_card;
  logic        r_cardValid;
  logic        r_ready;
  logic        r_shuffling;

  logic [15:0] w_lfsrNext;
  logic [5:0]  w_r;
  logic        w_accept;
  logic        w_shuffleDone;
  logic        w_initDone;
  logic        w_draw;
  logic [5:0]  w_postDraw;
  logic        w_reshuffle;
  logic [1:0]  w_initSuit;
  logic [5:0]  w_initOffset;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1; a nonzero state never reaches zero.
  assign w_lfsrNext    = (r_lfsr >> 1) ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  assign w_r           = r_lfsr[5:0];
  assign w_accept      = (r_state == SHUFFLE) && (w_r <= r_i);
  assign w_shuffleDone = w_accept && (r_i == 6'd1);
  assign w_initDone    = (r_state == INIT) && (r_k == 6'd51);
  assign w_draw        = (r_state == IDLE) && bus.i_drawReq;
  assign w_postDraw    = w_draw ? r_remaining - 6'd1 : r_remaining;
  assign w_reshuffle   = (r_state == IDLE) &&
                         (bus.i_shuffle ||
                          (bus.i_newRound && (w_postDraw < THRESH)) ||
                          (w_draw && (r_remaining == 6'd1)));

  always_comb begin
    w_initSuit   = 2'd0;
    w_initOffset = r_k;
    if (r_k >= 6'd39) begin
      w_initSuit   = 2'd3;
      w_initOffset = r_k - 6'd39;
    end else if (r_k >= 6'd26) begin
      w_initSuit   = 2'd2;
      w_initOffset = r_k - 6'd26;
    end else if (r_k >= 6'd13) begin
      w_initSuit   = 2'd1;
      w_initOffset = r_k - 6'd13;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= INIT;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      INIT:    if (w_initDone)    w_nextState = SHUFFLE;
      SHUFFLE: if (w_shuffleDone) w_nextState = IDLE;
      IDLE:    if (w_reshuffle)   w_nextState = INIT;
      default: w_nextState = INIT;
    endcase
  end

  // Deck storage needs no reset: INIT rewrites every slot before any card is dealt.
  always_ff @(posedge i_clk) begin
    if (r_state == INIT) begin
      r_deck[r_k] <= {w_initSuit, w_initOffset[3:0] + 4'd1};
    end else if (w_accept) begin
      r_deck[r_i] <= r_deck[w_r];
      r_deck[w_r] <= r_deck[r_i];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_lfsr      <= SEED;
      r_k         <= 6'd0;
      r_i         <= 6'd51;
      r_top       <= 6'd0;
      r_remaining <= 6'd0;
      r_card      <= 6'd0;
      r_cardValid <= 1'b0;
      r_ready     <= 1'b0;
      r_shuffling <= 1'b1;
    end else begin
      r_lfsr      <= w_lfsrNext;
      r_cardValid <= 1'b0;
      case (r_state)
        INIT: begin
          r_k <= r_k + 6'd1;
          if (w_initDone) begin
            r_k   <= 6'd0;
            r_i   <= 6'd51;
            r_top <= 6'd0;
          end
        end
        SHUFFLE: begin
          if (w_shuffleDone) begin
            r_ready     <= 1'b1;
            r_shuffling <= 1'b0;
            r_remaining <= 6'd52;
          end else if (w_accept) begin
            r_i <= r_i - 6'd1;
          end
        end
        IDLE: begin
          if (w_draw) begin
            r_card      <= r_deck[r_top];
            r_cardValid <= 1'b1;
            r_top       <= r_top + 6'd1;
            r_remaining <= r_remaining - 6'd1;
          end
          // A draw on the same edge is still served; the reshuffle just follows it.
          if (w_reshuffle) begin
            r_ready     <= 1'b0;
            r_shuffling <= 1'b1;
            r_remaining <= 6'd0;
            r_k         <= 6'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_card           = r_card;
  assign bus.o_cardValid      = r_cardValid;
  assign bus.o_ready          = r_ready;
  assign bus.o_shuffling      = r_shuffling;
  assign bus.o_cardsRemaining = r_remaining;

endmodule
